// File: rtl/debug_sequencer.sv
// Host-to-CPU debug command sequencer: memory/register access and bounded RUN
// with a fetch counter and watchdog. Every output is registered.
module debug_sequencer #(
  parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [15:0] cmd_addr,
  input  logic [15:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_ok,
  output logic        test,
  output logic        memoryoperation,
  output logic        registeroperation,
  output logic        memorywrite,
  output logic        registerwrite,
  output logic        sys_reset,
  output logic [15:0] memaddress,
  output logic [15:0] memwritedata,
  output logic [15:0] regwritedata,
  output logic [15:0] resetpc,
  output logic [3:0]  registeraddress,
  input  logic [15:0] MD,
  input  logic [15:0] RD,
  input  logic [15:0] PC,
  input  logic [8:0]  state
);

  // state   | meaning
  // IDLE    | waiting for a host command, cmd_ready=1
  // MRD     | memory read, 2 cycles
  // MWR     | memory write + readback verify, 3 cycles
  // RRD     | register read, 3 cycles
  // RWR     | register write, readback at cycle 3, 4 cycles
  // RUN_RST | CPU held in reset with resetpc applied, 1 cycle
  // RUN     | CPU running until N+1 fetches or watchdog expiry
  // RSP     | response held until rsp_ready
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_MRD     = 3'd1;
  localparam logic [2:0] S_MWR     = 3'd2;
  localparam logic [2:0] S_RRD     = 3'd3;
  localparam logic [2:0] S_RWR     = 3'd4;
  localparam logic [2:0] S_RUN_RST = 3'd5;
  localparam logic [2:0] S_RUN     = 3'd6;
  localparam logic [2:0] S_RSP     = 3'd7;

  logic [2:0]  r_state;
  logic [1:0]  r_cnt;
  logic [15:0] r_data;
  logic [16:0] r_fetch;
  logic [15:0] r_wd;

  logic        w_is_fetch;
  logic [16:0] w_fetch_next;
  logic [16:0] w_fetch_goal;
  logic [15:0] w_wd_next;

  assign w_is_fetch   = (state == 9'd1);
  assign w_fetch_next = r_fetch + {16'd0, w_is_fetch};
  assign w_fetch_goal = {1'b0, r_data} + 17'd1;
  assign w_wd_next    = r_wd + 16'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state           <= S_IDLE;
      r_cnt             <= 2'd0;
      r_data            <= 16'd0;
      r_fetch           <= 17'd0;
      r_wd              <= 16'd0;
      cmd_ready         <= 1'b1;
      rsp_valid         <= 1'b0;
      rsp_data          <= 16'd0;
      rsp_ok            <= 1'b0;
      test              <= 1'b0;
      memoryoperation   <= 1'b0;
      registeroperation <= 1'b0;
      memorywrite       <= 1'b0;
      registerwrite     <= 1'b0;
      sys_reset         <= 1'b0;
      memaddress        <= 16'd0;
      memwritedata      <= 16'd0;
      regwritedata      <= 16'd0;
      resetpc           <= 16'd0;
      registeraddress   <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            r_data    <= cmd_data;
            r_cnt     <= 2'd0;
            case (cmd_op)
              3'd0: begin
                r_state         <= S_MRD;
                memoryoperation <= 1'b1;
                memaddress      <= cmd_addr;
              end
              3'd1: begin
                r_state         <= S_MWR;
                memoryoperation <= 1'b1;
                memorywrite     <= 1'b1;
                memaddress      <= cmd_addr;
                memwritedata    <= cmd_data;
              end
              3'd2: begin
                r_state           <= S_RRD;
                registeroperation <= 1'b1;
                registeraddress   <= cmd_addr[3:0];
              end
              3'd3: begin
                r_state           <= S_RWR;
                registeroperation <= 1'b1;
                registerwrite     <= 1'b1;
                registeraddress   <= cmd_addr[3:0];
                regwritedata      <= cmd_data;
              end
              3'd4: begin
                r_state   <= S_RUN_RST;
                test      <= 1'b1;
                sys_reset <= 1'b1;
                resetpc   <= cmd_addr;
              end
              default: begin
                r_state   <= S_RSP;
                rsp_valid <= 1'b1;
                rsp_ok    <= 1'b0;
                rsp_data  <= 16'd0;
              end
            endcase
          end
        end
        S_MRD: begin
          if (r_cnt == 2'd1) begin
            r_state         <= S_RSP;
            memoryoperation <= 1'b0;
            rsp_valid       <= 1'b1;
            rsp_data        <= MD;
            rsp_ok          <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        S_MWR: begin
          if (r_cnt == 2'd2) begin
            r_state         <= S_RSP;
            memoryoperation <= 1'b0;
            memorywrite     <= 1'b0;
            rsp_valid       <= 1'b1;
            rsp_data        <= MD;
            rsp_ok          <= (MD == r_data);
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        S_RRD: begin
          if (r_cnt == 2'd2) begin
            r_state           <= S_RSP;
            registeroperation <= 1'b0;
            rsp_valid         <= 1'b1;
            rsp_data          <= RD;
            rsp_ok            <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        S_RWR: begin
          // readback is taken one cycle before the strobes drop
          if (r_cnt == 2'd2) begin
            rsp_data <= RD;
            rsp_ok   <= (RD == r_data);
          end
          if (r_cnt == 2'd3) begin
            r_state           <= S_RSP;
            registeroperation <= 1'b0;
            registerwrite     <= 1'b0;
            rsp_valid         <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        S_RUN_RST: begin
          r_state   <= S_RUN;
          sys_reset <= 1'b0;
          r_fetch   <= 17'd0;
          r_wd      <= 16'd0;
        end
        S_RUN: begin
          // completion is tested first so it wins a tie with the watchdog
          if (w_fetch_next == w_fetch_goal) begin
            r_state   <= S_RSP;
            test      <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_data  <= PC;
            rsp_ok    <= 1'b1;
          end else if (w_wd_next == TIMEOUT) begin
            r_state   <= S_RSP;
            test      <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_data  <= PC;
            rsp_ok    <= 1'b0;
          end else begin
            r_fetch <= w_fetch_next;
            r_wd    <= w_wd_next;
          end
        end
        S_RSP: begin
          if (rsp_ready) begin
            r_state   <= S_IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_sequencer.sv
// Bench for debug_sequencer: a small CPU stub answers the debug port; random
// memory/register traffic is scored against plain arrays, plus directed cases.
module tb_debug_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_addr, cmd_data;
  logic        rsp_valid, rsp_ready, rsp_ok;
  logic [15:0] rsp_data;
  logic        test, memoryoperation, registeroperation, memorywrite, registerwrite, sys_reset;
  logic [15:0] memaddress, memwritedata, regwritedata, resetpc;
  logic [3:0]  registeraddress;
  logic [15:0] MD, RD, PC;
  logic [8:0]  state;

  always #5 clk = ~clk;

  debug_sequencer #(.TIMEOUT(16'd20)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_ok(rsp_ok),
    .test(test), .memoryoperation(memoryoperation), .registeroperation(registeroperation),
    .memorywrite(memorywrite), .registerwrite(registerwrite), .sys_reset(sys_reset),
    .memaddress(memaddress), .memwritedata(memwritedata), .regwritedata(regwritedata),
    .resetpc(resetpc), .registeraddress(registeraddress),
    .MD(MD), .RD(RD), .PC(PC), .state(state)
  );

  // CPU stub. mode 0: fetch/execute alternating; 1: stalled; 2: fetch every cycle
  logic [15:0] mem [65536];
  logic [15:0] regs [16];
  logic [15:0] cpu_pc, cpu_ir;
  logic [1:0]  cpu_st, cpu_mode;
  logic        blk_mem, blk_reg, stub_clr;

  assign MD = mem[memaddress];
  assign RD = regs[registeraddress];
  assign PC = cpu_pc;
  assign state = (cpu_st == 2'd0) ? 9'd0 :
                 (cpu_mode == 2'd1) ? 9'd4 :
                 (cpu_mode == 2'd2) ? 9'd1 :
                 (cpu_st == 2'd1) ? 9'd1 : 9'd2;

  always @(posedge clk) begin
    if (stub_clr) begin
      for (int i = 0; i < 65536; i++) mem[i] <= 16'd0;
      for (int i = 0; i < 16; i++) regs[i] <= 16'd0;
      cpu_pc <= 16'd0; cpu_ir <= 16'd0; cpu_st <= 2'd0;
    end else begin
      if (memoryoperation && memorywrite && !blk_mem) mem[memaddress] <= memwritedata;
      if (registeroperation && registerwrite && !blk_reg) regs[registeraddress] <= regwritedata;
      if (test && sys_reset) begin
        cpu_pc <= resetpc; cpu_st <= 2'd1;
      end else if (test && cpu_st != 2'd0) begin
        if (cpu_mode == 2'd2) cpu_pc <= cpu_pc + 16'd1;
        else if (cpu_mode == 2'd0) begin
          if (cpu_st == 2'd1) begin
            cpu_ir <= mem[cpu_pc]; cpu_st <= 2'd2;
          end else begin
            if (cpu_ir[15:12] == 4'h7) regs[cpu_ir[11:8]] <= {{8{cpu_ir[7]}}, cpu_ir[7:0]};
            else if (cpu_ir[15:12] == 4'h0) regs[cpu_ir[11:8]] <= regs[cpu_ir[11:8]] + regs[cpu_ir[7:4]];
            cpu_pc <= cpu_pc + 16'd1; cpu_st <= 2'd1;
          end
        end
      end else if (!test) cpu_st <= 2'd0;
    end
  end

  int excl_viol = 0;
  always @(negedge clk)
    if ($countones({memoryoperation, registeroperation, test}) > 1) excl_viol++;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [15:0] data;
    logic        ok;
    int          lat;
    int          nm, nmw, nr, nrw, nt, nrs;
    logic        rsp_bad;
    logic        idle_ok;
  } res_t;

  // Issue one command at a negedge, count strobe cycles until the response,
  // hold rsp_ready low for 'hold' cycles, then consume.
  task automatic do_cmd(input logic [2:0] op, input logic [15:0] addr, input logic [15:0] data,
                        input int hold, output res_t r);
    int guard;
    guard = 0;
    r.nm = 0; r.nmw = 0; r.nr = 0; r.nrw = 0; r.nt = 0; r.nrs = 0; r.lat = 0;
    r.rsp_bad = 1'b0;
    while (!cmd_ready && guard < 50) begin @(negedge clk); guard++; end
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 3'($urandom); cmd_addr = 16'($urandom); cmd_data = 16'($urandom);
    while (!rsp_valid && r.lat < 200) begin
      r.nm  += int'(memoryoperation);
      r.nmw += int'(memorywrite);
      r.nr  += int'(registeroperation);
      r.nrw += int'(registerwrite);
      r.nt  += int'(test);
      r.nrs += int'(sys_reset);
      r.lat++;
      @(negedge clk);
    end
    if (!rsp_valid) check("rsp_wait_bound", 64'(r.lat), 64'd0);
    r.data = rsp_data; r.ok = rsp_ok;
    for (int i = 0; i <= hold; i++) begin
      if (i > 0) @(negedge clk);
      if (!rsp_valid || rsp_data !== r.data || rsp_ok !== r.ok ||
          (test | memoryoperation | registeroperation | memorywrite | registerwrite | sys_reset))
        r.rsp_bad = 1'b1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    r.idle_ok = cmd_ready && !rsp_valid;
  endtask

  function automatic logic [63:0] exp_strobes(input logic [2:0] op, input int lat);
    int nm, nmw, nr, nrw, nt, nrs;
    nm = 0; nmw = 0; nr = 0; nrw = 0; nt = 0; nrs = 0;
    case (op)
      3'd0: nm = 2;
      3'd1: begin nm = 3; nmw = 3; end
      3'd2: nr = 3;
      3'd3: begin nr = 4; nrw = 4; end
      3'd4: begin nt = lat; nrs = 1; end
      default: ;
    endcase
    return {8'(nm), 8'(nmw), 8'(nr), 8'(nrw), 8'(nt), 8'(nrs), 16'd0};
  endfunction

  function automatic int exp_lat_mem(input logic [2:0] op);
    case (op)
      3'd0: return 2;
      3'd1: return 3;
      3'd2: return 3;
      3'd3: return 4;
      default: return 0;
    endcase
  endfunction

  task automatic check_res(input string tag, input logic [2:0] op, input res_t r,
                           input logic [15:0] ed, input logic eok, input int elat);
    check({tag, "_data"}, 64'(r.data), 64'(ed));
    check({tag, "_ok"}, 64'(r.ok), 64'(eok));
    check({tag, "_latency"}, 64'(r.lat), 64'(elat));
    check({tag, "_strobes"}, {8'(r.nm), 8'(r.nmw), 8'(r.nr), 8'(r.nrw), 8'(r.nt), 8'(r.nrs), 16'd0},
          exp_strobes(op, elat));
    check({tag, "_rsp_hold"}, 64'(r.rsp_bad), 64'd0);
    check({tag, "_back_to_idle"}, 64'(r.idle_ok), 64'd1);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [15:0] addr, data, exp_data;
    logic        exp_ok;
    int          exp_lat;
  } vec_t;

  vec_t        tbl [13];
  logic [15:0] ref_mem [16];
  logic [15:0] ref_reg [16];
  res_t        r;
  logic [2:0]  op;
  logic [15:0] a, d, ed;
  logic        eok, bad;

  initial begin
    tbl[0]  = '{3'd1, 16'd1,  16'h70FF, 16'h70FF, 1'b1, 3};
    tbl[1]  = '{3'd0, 16'd1,  16'h0000, 16'h70FF, 1'b1, 2};
    tbl[2]  = '{3'd1, 16'd2,  16'h7105, 16'h7105, 1'b1, 3};
    tbl[3]  = '{3'd4, 16'd1,  16'd2,    16'd3,    1'b1, 6};
    tbl[4]  = '{3'd2, 16'd0,  16'h0000, 16'hFFFF, 1'b1, 3};
    tbl[5]  = '{3'd2, 16'd1,  16'h0000, 16'h0005, 1'b1, 3};
    tbl[6]  = '{3'd3, 16'd1,  16'd2,    16'd2,    1'b1, 4};
    tbl[7]  = '{3'd3, 16'd3,  16'd10,   16'd10,   1'b1, 4};
    tbl[8]  = '{3'd1, 16'd10, 16'h0137, 16'h0137, 1'b1, 3};
    tbl[9]  = '{3'd4, 16'd10, 16'd1,    16'd11,   1'b1, 4};
    tbl[10] = '{3'd2, 16'd1,  16'h0000, 16'h000C, 1'b1, 3};
    tbl[11] = '{3'd4, 16'd5,  16'd0,    16'd5,    1'b1, 2};
    tbl[12] = '{3'd7, 16'd9,  16'd9,    16'd0,    1'b0, 0};

    reset = 1'b1; stub_clr = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_addr = 16'd0;
    cmd_data = 16'd0; rsp_ready = 1'b0; cpu_mode = 2'd0; blk_mem = 1'b0; blk_reg = 1'b0;
    for (int i = 0; i < 16; i++) begin ref_mem[i] = 16'd0; ref_reg[i] = 16'd0; end
    repeat (3) @(negedge clk);
    check("reset_rsp", {rsp_valid, rsp_ok, rsp_data}, 64'd0);
    check("reset_strobes", {test, memoryoperation, registeroperation, memorywrite, registerwrite, sys_reset}, 64'd0);
    check("reset_addr_data", {memaddress, memwritedata, regwritedata, resetpc, registeraddress}, 64'd0);
    reset = 1'b0; stub_clr = 1'b0;
    @(negedge clk);
    check("cmd_ready_after_reset", 64'(cmd_ready), 64'd1);

    // random memory/register traffic against array reference
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0, 1:    op = 3'd0;
        2, 3:    op = 3'd1;
        4, 5:    op = 3'd2;
        6, 7:    op = 3'd3;
        default: op = 3'($urandom_range(5, 7));
      endcase
      d = 16'($urandom);
      a = (op <= 3'd1) ? 16'($urandom_range(0, 15)) : 16'($urandom);
      blk_mem = (op == 3'd1) && ($urandom_range(0, 5) == 0);
      blk_reg = (op == 3'd3) && ($urandom_range(0, 5) == 0);
      case (op)
        3'd0: begin ed = ref_mem[a[3:0]]; eok = 1'b1; end
        3'd1: begin
          ed = blk_mem ? ref_mem[a[3:0]] : d;
          eok = (ed == d);
          ref_mem[a[3:0]] = ed;
        end
        3'd2: begin ed = ref_reg[a[3:0]]; eok = 1'b1; end
        3'd3: begin
          ed = blk_reg ? ref_reg[a[3:0]] : d;
          eok = (ed == d);
          ref_reg[a[3:0]] = ed;
        end
        default: begin ed = 16'd0; eok = 1'b0; end
      endcase
      do_cmd(op, a, d, $urandom_range(0, 3), r);
      blk_mem = 1'b0; blk_reg = 1'b0;
      check_res($sformatf("rand%0d_op%0d", n, op), op, r, ed, eok, exp_lat_mem(op));
    end

    // directed program sequence through the CPU stub
    foreach (tbl[i]) begin
      do_cmd(tbl[i].op, tbl[i].addr, tbl[i].data, 1, r);
      check_res($sformatf("vec%0d", i), tbl[i].op, r, tbl[i].exp_data, tbl[i].exp_ok, tbl[i].exp_lat);
    end

    // stalled CPU: watchdog fires 20 cycles after RUN entry, PC reported
    cpu_mode = 2'd1;
    do_cmd(3'd4, 16'h0022, 16'd1, 0, r);
    check_res("stall_timeout", 3'd4, r, 16'h0022, 1'b0, 21);
    do_cmd(3'd4, 16'h0033, 16'hFFFF, 0, r);
    check_res("stall_n_ffff", 3'd4, r, 16'h0033, 1'b0, 21);
    cpu_mode = 2'd0;
    do_cmd(3'd0, 16'd10, 16'd0, 0, r);
    check_res("mrd_after_timeout", 3'd0, r, 16'h0137, 1'b1, 2);

    // fetch every cycle: completion on cycle 20 ties the watchdog and wins
    cpu_mode = 2'd2;
    do_cmd(3'd4, 16'h0040, 16'd19, 0, r);
    check_res("tie_completion_wins", 3'd4, r, 16'h0053, 1'b1, 21);
    do_cmd(3'd4, 16'h0040, 16'd20, 0, r);
    check_res("one_past_tie_times_out", 3'd4, r, 16'h0053, 1'b0, 21);
    cpu_mode = 2'd0;

    // illegal op held for 5 cycles
    do_cmd(3'd6, 16'h1234, 16'h5678, 5, r);
    check_res("illegal_op6_hold5", 3'd6, r, 16'h0000, 1'b0, 0);

    // reset during the 2nd cycle of RWR drops the command
    cmd_valid = 1'b1; cmd_op = 3'd3; cmd_addr = 16'd4; cmd_data = 16'h1234;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("rwr_cycle1_regwrite", 64'(registerwrite), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_mid_rwr_strobes", {registerwrite, registeroperation, rsp_valid}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("reset_mid_rwr_ready", {cmd_ready, rsp_valid}, 64'b10);
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid || registeroperation) bad = 1'b1;
    end
    check("reset_mid_rwr_no_response", 64'(bad), 64'd0);
    do_cmd(3'd2, 16'd1, 16'd0, 0, r);
    check_res("rrd_after_reset", 3'd2, r, 16'h000C, 1'b1, 3);

    check("strobe_exclusivity", 64'(excl_viol), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/debug_sequencer.md
DEBUG_SEQUENCER -- requirements
Module: debug_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 16'hFFFF, maximum cycles a RUN command may take before it is aborted.
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 cmd_valid  in  1  host command present.
REQ-005 cmd_ready  out  1  sequencer accepts the command this cycle.
REQ-006 cmd_op  in  3  0=MRD, 1=MWR, 2=RRD, 3=RWR, 4=RUN, 5-7 illegal.
REQ-007 cmd_addr  in  16  memory address, register index (bits 3:0), or RUN start PC.
REQ-008 cmd_data  in  16  write data, or RUN instruction count N.
REQ-009 rsp_valid  out  1  response available.
REQ-010 rsp_ready  in  1  host consumes response.
REQ-011 rsp_data  out  16  read data, or final PC for RUN.
REQ-012 rsp_ok  out  1  1=success; 0=illegal op, write-verify mismatch, or RUN timeout.
REQ-013 test, memoryoperation, registeroperation, memorywrite, registerwrite, sys_reset  out  1 each  drive the CPU debug port.
REQ-014 memaddress, memwritedata, regwritedata, resetpc  out  16 each  CPU debug data/address.
REQ-015 registeraddress  out  4  CPU register index.
REQ-016 MD, RD, PC  in  16 each  CPU memory data, register data, program counter.
REQ-017 state  in  9  CPU control state; value 9'd1 means fetch.

Function
REQ-018 FSM states: IDLE, MRD, MWR, RRD, RWR, RUN_RST, RUN, RSP.
REQ-019 cmd_ready = 1 only in IDLE; a command is accepted on a cycle with cmd_valid & cmd_ready, and op/addr/data are latched then.
REQ-020 MRD: 2 cycles with memoryoperation=1 and memaddress=addr; MD is captured at the end of the 2nd cycle; rsp_ok=1.
REQ-021 MWR: 3 cycles with memoryoperation=1, memorywrite=1, memaddress=addr and memwritedata=data; MD is compared with data at the end; rsp_ok=(MD==data); rsp_data=MD.
REQ-022 RRD: 3 cycles with registeroperation=1 and registeraddress=addr[3:0]; RD is captured at the end of the 3rd cycle; rsp_ok=1.
REQ-023 RWR: 4 cycles with registeroperation=1, registerwrite=1 and regwritedata=data; RD is compared at the end of the 3rd cycle; rsp_ok=(RD==data); rsp_data=RD.
REQ-024 RUN_RST: 1 cycle with test=1, sys_reset=1 and resetpc=addr.
REQ-025 RUN: test=1 and sys_reset=0; a fetch counter of width 17 is cleared on entry and counts cycles where state==9'd1.
REQ-026 RUN completes on the cycle the counter reaches N+1; rsp_data=PC of that cycle; rsp_ok=1.
REQ-027 N=0 completes on the first fetch; N=16'hFFFF does not wrap, because the counter is 17 bits.
REQ-028 RUN watchdog: a cycle counter starts at RUN entry; if it reaches TIMEOUT before completion, RUN aborts with rsp_ok=0 and rsp_data=PC.
REQ-029 If completion and timeout occur in the same cycle, completion wins.
REQ-030 Illegal op: go directly to RSP the cycle after acceptance, with rsp_ok=0 and rsp_data=0.
REQ-031 In RSP, all CPU debug strobes (test, *operation, *write, sys_reset) are 0.
REQ-032 In RSP, rsp_valid=1, and rsp_data/rsp_ok are held stable until rsp_ready.
REQ-033 The RSP->IDLE transition happens on the rsp_ready cycle.
REQ-034 Outside its owning state each strobe is 0, and at most one of memoryoperation/registeroperation/test is 1 in any cycle.
REQ-035 All outputs are registered; no combinational path from MD/RD/PC/state to outputs.

Reset
REQ-036 reset, whether idle or mid-command, returns the FSM to IDLE on the next edge.
REQ-037 On reset, all strobes, counters, rsp_valid, rsp_ok and rsp_data are set to 0, and all address/data outputs are set to 0.
REQ-038 On reset, cmd_ready=1 the cycle after reset deasserts.
REQ-039 A command in flight during reset is dropped without a response.

Verification
REQ-040 MWR addr=1 data=16'h70FF, then MRD addr=1 -> MWR gives rsp_ok=1; MRD gives rsp_data=16'h70FF.
REQ-041 MWR 2=16'h7105; RUN addr=1 N=2; then RRD 0 and RRD 1 -> RUN rsp_ok=1; RRD 0 gives 16'hFFFF; RRD 1 gives 16'h0005.
REQ-042 RWR 1=2, RWR 3=10, MWR 10=16'h0137, RUN addr=10 N=1, RRD 1 -> 16'h000C.
REQ-043 TIMEOUT=20, CPU stalled with state never 1, RUN N=1 -> rsp_valid on cycle 20 after RUN entry with rsp_ok=0; a following MRD completes normally.
REQ-044 cmd_op=6 -> rsp_valid with rsp_ok=0 and no strobe ever asserted; holding rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data held stable throughout.
REQ-045 reset in the 2nd cycle of RWR -> registerwrite=0 on the next cycle, no response, cmd_ready=1 the cycle after reset drops.
